// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester ports 0/1, RAM bus and status signals of ram_arbiter.
// The slave modport is the arbiter's view; the master modport is the side that
// drives requests and hosts the RAM.
// Optional feature macro: RAM_ARB_FAULT_EN adds the fault0/fault1 outputs.
`timescale 1ns/1ps
interface ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    logic              busy;

`ifdef RAM_ARB_FAULT_EN
    logic              fault0;
    logic              fault1;

    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        input  ram_q,
        output ack0, rdata0, ack1, rdata1,
        output ram_a, ram_d, ram_re, ram_we,
        output busy, fault0, fault1
    );

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        output ram_q,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_a, ram_d, ram_re, ram_we,
        input  busy, fault0, fault1
    );
`else
    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        input  ram_q,
        output ack0, rdata0, ack1, rdata1,
        output ram_a, ram_d, ram_re, ram_we,
        output busy
    );

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        output ram_q,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_a, ram_d, ram_re, ram_we,
        input  busy
    );
`endif
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and sequencer between the CPU path (port 0)
// and the DMA/loader path (port 1) in front of the LSU's registered 32K x 8 RAM.
// Every access walks IDLE -> ISSUE -> CAPTURE -> DONE, so one access completes
// every 4 cycles with a single-cycle ack to the winning port.
// Optional feature macro: RAM_ARB_FAULT_EN -- out-of-range accesses are not
// issued to the RAM, reads return all ones and fault0/fault1 pulse with the ack.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int RAM_SIZE = 32768
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_stateNxt;
    logic              r_grant;
    logic              w_grantNxt;
    logic              r_lastGrant;
    logic              w_lastGrantNxt;
    logic              r_wr;
    logic              w_wrNxt;
    logic              r_oor;
    logic              w_oorNxt;
    logic [ADDR_W-1:0] r_ramA;
    logic [ADDR_W-1:0] w_ramANxt;
    logic [DATA_W-1:0] r_ramD;
    logic [DATA_W-1:0] w_ramDNxt;
    logic              r_ramRe;
    logic              w_ramReNxt;
    logic              r_ramWe;
    logic              w_ramWeNxt;
    logic              r_ack0;
    logic              w_ack0Nxt;
    logic              r_ack1;
    logic              w_ack1Nxt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] w_rdata0Nxt;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] w_rdata1Nxt;
    logic              r_busy;
    logic              w_busyNxt;

    logic              w_sel;
    logic              w_selWr;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selData;
    logic              w_selOor;
    logic [DATA_W-1:0] w_capData;

    // A RAM larger than the address space could never be fully reached
    if (longint'(RAM_SIZE) > (longint'(1) << ADDR_W)) begin : g_ramSizeCheck
        $error("ram_arbiter: RAM_SIZE exceeds the ADDR_W address space");
    end

    // Round-robin pick: a lone request wins outright, a tie goes to the port
    // that did not win last time (last_grant resets to 1 so port 0 wins first)
    assign w_sel     = (bus.req0 && bus.req1) ? ~r_lastGrant : bus.req1;
    assign w_selWr   = w_sel ? bus.wr1    : bus.wr0;
    assign w_selAddr = w_sel ? bus.addr1  : bus.addr0;
    assign w_selData = w_sel ? bus.wdata1 : bus.wdata0;

`ifdef RAM_ARB_FAULT_EN
    localparam logic [ADDR_W:0] LP_RAM_SIZE = (ADDR_W + 1)'(RAM_SIZE);
    assign w_selOor = ({1'b0, w_selAddr} >= LP_RAM_SIZE);
`else
    assign w_selOor = 1'b0;
`endif

    // Suppressed out-of-range reads return all ones instead of RAM data
    assign w_capData = r_oor ? {DATA_W{1'b1}} : bus.ram_q;

    // Next-state and next-output logic; registers hold unless a state changes them
    always_comb begin
        w_stateNxt     = r_state;
        w_grantNxt     = r_grant;
        w_lastGrantNxt = r_lastGrant;
        w_wrNxt        = r_wr;
        w_oorNxt       = r_oor;
        w_ramANxt      = r_ramA;
        w_ramDNxt      = r_ramD;
        w_rdata0Nxt    = r_rdata0;
        w_rdata1Nxt    = r_rdata1;
        w_ramReNxt     = 1'b0;
        w_ramWeNxt     = 1'b0;
        w_ack0Nxt      = 1'b0;
        w_ack1Nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grantNxt     = w_sel;
                    w_lastGrantNxt = w_sel;
                    w_wrNxt        = w_selWr;
                    w_oorNxt       = w_selOor;
                    w_ramANxt      = w_selAddr;
                    w_ramDNxt      = w_selData;
                    w_ramWeNxt     = w_selWr && !w_selOor;
                    w_ramReNxt     = !w_selWr && !w_selOor;
                    w_stateNxt     = ISSUE;
                end
            end
            ISSUE: begin
                w_stateNxt = CAPTURE;
            end
            CAPTURE: begin
                if (!r_wr) begin
                    if (r_grant) begin
                        w_rdata1Nxt = w_capData;
                    end else begin
                        w_rdata0Nxt = w_capData;
                    end
                end
                w_ack0Nxt  = !r_grant;
                w_ack1Nxt  = r_grant;
                w_stateNxt = DONE;
            end
            DONE: begin
                w_stateNxt = IDLE;
            end
            default: begin
                w_stateNxt = IDLE;
            end
        endcase

        w_busyNxt = (w_stateNxt != IDLE);
    end

    // State and output registers; a synchronous reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_wr        <= 1'b0;
            r_oor       <= 1'b0;
            r_ramA      <= '0;
            r_ramD      <= '0;
            r_ramRe     <= 1'b0;
            r_ramWe     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_stateNxt;
            r_grant     <= w_grantNxt;
            r_lastGrant <= w_lastGrantNxt;
            r_wr        <= w_wrNxt;
            r_oor       <= w_oorNxt;
            r_ramA      <= w_ramANxt;
            r_ramD      <= w_ramDNxt;
            r_ramRe     <= w_ramReNxt;
            r_ramWe     <= w_ramWeNxt;
            r_ack0      <= w_ack0Nxt;
            r_ack1      <= w_ack1Nxt;
            r_rdata0    <= w_rdata0Nxt;
            r_rdata1    <= w_rdata1Nxt;
            r_busy      <= w_busyNxt;
        end
    end

`ifdef RAM_ARB_FAULT_EN
    logic r_fault0;
    logic r_fault1;

    // Fault flags pulse together with the ack of a suppressed out-of-range access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault0 <= 1'b0;
            r_fault1 <= 1'b0;
        end else begin
            r_fault0 <= w_ack0Nxt && r_oor;
            r_fault1 <= w_ack1Nxt && r_oor;
        end
    end

    assign bus.fault0 = r_fault0;
    assign bus.fault1 = r_fault1;
`endif

    assign bus.ram_a  = r_ramA;
    assign bus.ram_d  = r_ramD;
    assign bus.ram_re = r_ramRe;
    assign bus.ram_we = r_ramWe;
    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
    assign bus.busy   = r_busy;

endmodule
